regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_wb_arbiter_rr_arb2.sv | 31 +++
 rtl/regfile_wb_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the register file and its writeback logic.
package regfile_pkg;
    localparam int unsigned DW   = 64;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-requester round-robin grant; after any grant the loser gets priority next time.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_req_a,
    input  logic i_req_b,
    output logic o_gnt_a,
    output logic o_gnt_b
);
    logic r_ptr_b;
    logic w_gnt_a;
    logic w_gnt_b;

    // r_ptr_b = 1 means B wins a tie
    assign w_gnt_a = i_en & i_req_a & (~i_req_b | ~r_ptr_b);
    assign w_gnt_b = i_en & i_req_b & (~i_req_a |  r_ptr_b);

    assign o_gnt_a = w_gnt_a;
    assign o_gnt_b = w_gnt_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr_b <= 1'b0;
        end else if (w_gnt_a) begin
            r_ptr_b <= 1'b1;
        end else if (w_gnt_b) begin
            r_ptr_b <= 1'b0;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write port arbiter: clears every register after reset or init_req,
// then merges ALU (A) and load (B) writebacks round-robin with one write per cycle.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DW       = regfile_pkg::DW,
    parameter int unsigned AW       = regfile_pkg::AW,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    input  logic          init_req,
    output logic          busy,
    output logic          W_En,
    output logic [AW-1:0] W_Addr,
    output logic [DW-1:0] WR
);
    state_t        r_state;
    logic [AW:0]   r_cnt;
    logic          r_wen;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_wdata;

    logic          w_run;
    logic          w_gnt_a;
    logic          w_gnt_b;
    logic          w_hs;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          w_zero_hit;

    assign w_run = (r_state == RUN) && !init_req;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (reset),
        .i_en    (w_run),
        .i_req_a (a_valid),
        .i_req_b (b_valid),
        .o_gnt_a (w_gnt_a),
        .o_gnt_b (w_gnt_b)
    );

    assign a_ready    = w_gnt_a;
    assign b_ready    = w_gnt_b;
    assign busy       = (r_state == CLEAR);
    assign w_hs       = w_gnt_a | w_gnt_b;
    assign w_addr     = w_gnt_a ? a_addr : b_addr;
    assign w_data     = w_gnt_a ? a_data : b_data;
    assign w_zero_hit = (ZERO_REG != 0) && (w_addr == '0);

    // The extra counter bit marks the idle cycle between the last sweep write and RUN,
    // so busy covers every sweep write seen on the port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (init_req) begin
                        r_cnt <= '0;
                        r_wen <= 1'b0;
                    end else if (!r_cnt[AW]) begin
                        r_wen   <= 1'b1;
                        r_waddr <= r_cnt[AW-1:0];
                        r_wdata <= '0;
                        r_cnt   <= r_cnt + 1'b1;
                    end else begin
                        r_wen   <= 1'b0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (init_req) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                        r_wen   <= 1'b0;
                    end else if (w_hs && !w_zero_hit) begin
                        r_wen   <= 1'b1;
                        r_waddr <= w_addr;
                        r_wdata <= w_data;
                    end else begin
                        r_wen <= 1'b0;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_cnt   <= '0;
                    r_wen   <= 1'b0;
                end
            endcase
        end
    end

    assign W_En   = r_wen;
    assign W_Addr = r_waddr;
    assign WR     = r_wdata;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: sweep, single/dual requesters, zero register,
// init_req restart and asynchronous reset mid-sweep.
module tb_regfile_wb_arbiter;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_valid, b_valid;
    logic          a_ready, b_ready;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic          init_req;
    logic          busy;
    logic          W_En;
    logic [AW-1:0] W_Addr;
    logic [DW-1:0] WR;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    regfile_wb_arbiter #(.DW(DW), .AW(AW), .ZERO_REG(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .init_req (init_req),
        .busy     (busy),
        .W_En     (W_En),
        .W_Addr   (W_Addr),
        .WR       (WR)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [AW-1:0] ai, bi;
    logic          exp_a [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        reset    = 1'b1;
        a_valid  = 1'b1;
        a_addr   = 5'd2;
        a_data   = 64'h22;
        b_valid  = 1'b0;
        b_addr   = '0;
        b_data   = '0;
        init_req = 1'b0;
        #12;
        check("rst_busy",   busy,    1);
        check("rst_aready", a_ready, 0);
        check("rst_wen",    W_En,    0);
        check("rst_waddr",  W_Addr,  0);
        check("rst_wr",     WR,      0);

        // Sweep after reset release, A already waiting with addr 2
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step();
            check("sw_wen",    W_En,    1);
            check("sw_waddr",  W_Addr,  i);
            check("sw_wr",     WR,      0);
            check("sw_busy",   busy,    1);
            check("sw_aready", a_ready, 0);
        end
        step();
        check("end_busy",   busy,    0);
        check("end_wen",    W_En,    0);
        check("end_aready", a_ready, 1);
        check("end_bready", b_ready, 0);
        step();
        check("a2_wen",   W_En,   1);
        check("a2_waddr", W_Addr, 2);
        check("a2_wr",    WR,     64'h22);

        // B alone (pointer now favours B, and afterwards A)
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b1;
        b_addr  = 5'd7;
        b_data  = 64'hDEADBEEF_00000001;
        #1;
        check("b7_bready", b_ready, 1);
        check("b7_aready", a_ready, 0);
        step();
        check("b7_wen",   W_En,   1);
        check("b7_waddr", W_Addr, 7);
        check("b7_wr",    WR,     64'hDEADBEEF_00000001);

        // Both valid: A 3..6, B 10..13 -> A,B,A,B
        ai = 5'd3;
        bi = 5'd10;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a_valid = 1'b1;
            a_addr  = ai;
            a_data  = 64'h100 + 64'(ai);
            b_valid = 1'b1;
            b_addr  = bi;
            b_data  = 64'h200 + 64'(bi);
            #1;
            check("rr_aready", a_ready, exp_a[k]);
            check("rr_bready", b_ready, !exp_a[k]);
            step();
            check("rr_wen",   W_En,   1);
            check("rr_waddr", W_Addr, exp_a[k] ? ai : bi);
            check("rr_wr",    WR,     exp_a[k] ? 64'h100 + 64'(ai) : 64'h200 + 64'(bi));
            if (exp_a[k]) ai = ai + 1'b1;
            else          bi = bi + 1'b1;
        end

        // Idle: outputs hold
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();
        check("idle_wen",   W_En,   0);
        check("idle_waddr", W_Addr, 11);
        check("idle_wr",    WR,     64'h20B);

        // Zero register: handshake completes, no write
        @(negedge clk);
        a_valid = 1'b1;
        a_addr  = 5'd0;
        a_data  = 64'h5;
        #1;
        check("z_aready", a_ready, 1);
        step();
        check("z_wen",   W_En,   0);
        check("z_waddr", W_Addr, 11);

        // init_req while A waits with addr 9
        @(negedge clk);
        a_addr   = 5'd9;
        a_data   = 64'h99;
        init_req = 1'b1;
        #1;
        check("ir_aready", a_ready, 0);
        step();
        check("ir_busy", busy, 1);
        check("ir_wen",  W_En, 0);
        @(negedge clk);
        init_req = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step();
            check("ir_sw_waddr", W_Addr,  i);
            check("ir_sw_wen",   W_En,    1);
            check("ir_sw_wr",    WR,      0);
            check("ir_sw_aready", a_ready, 0);
        end
        step();
        check("ir_end_busy",   busy,    0);
        check("ir_end_aready", a_ready, 1);
        step();
        check("a9_wen",   W_En,   1);
        check("a9_waddr", W_Addr, 9);
        check("a9_wr",    WR,     64'h99);
        @(negedge clk);
        a_valid = 1'b0;

        // Async reset at sweep address 17
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        for (int i = 0; i < 18; i++) step();
        check("pre_rst_waddr", W_Addr, 17);
        #2;
        reset = 1'b1;
        #1;
        check("ar_wen",   W_En,   0);
        check("ar_waddr", W_Addr, 0);
        check("ar_wr",    WR,     0);
        check("ar_busy",  busy,   1);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("ar_sw_wen",   W_En,   1);
        check("ar_sw_waddr", W_Addr, 0);
        step();
        check("ar_sw_waddr1", W_Addr, 1);
        for (int i = 0; i < 31; i++) step();
        check("ar_end_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
